// File: rtl/ahb_master_arbiter.sv
// rtl/ahb_master_arbiter.sv - two-master round-robin arbiter and AHB burst sequencer
// Grants one master per burst, then issues every beat's address phase and pipelines write data.
module ahb_master_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          hreset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_haddr,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [2:0]    m0_hburst,
    input  logic [1:0]    m0_hsel,
    input  logic [DW-1:0] m0_hwdata,
    output logic          m0_grant,
    output logic          m0_beat_ack,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_haddr,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [2:0]    m1_hburst,
    input  logic [1:0]    m1_hsel,
    input  logic [DW-1:0] m1_hwdata,
    output logic          m1_grant,
    output logic          m1_beat_ack,
    input  logic          hready,
    output logic          out_enable,
    output logic [AW-1:0] out_haddr,
    output logic [1:0]    out_htrans,
    output logic          out_hwrite,
    output logic [2:0]    out_hsize,
    output logic [2:0]    out_hburst,
    output logic [1:0]    out_hsel,
    output logic [DW-1:0] out_hwdata,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t        r_state, w_next;
    logic          r_last_grant, r_owner;
    logic          r_m0_grant, r_m1_grant, r_m0_ack, r_m1_ack;
    logic          r_enable, r_busy, r_hwrite;
    logic [AW-1:0] r_haddr;
    logic [1:0]    r_htrans, r_hsel;
    logic [2:0]    r_hsize, r_hburst;
    logic [DW-1:0] r_hwdata;
    logic [3:0]    r_beats_left;

    // Remaining beats after the first; INCR (001) shares 000's encoding but is req-terminated
    function automatic logic [3:0] f_beats_left(input logic [2:0] burst);
        case (burst[2:1])
            2'b00:   f_beats_left = 4'd0;
            2'b01:   f_beats_left = 4'd3;
            2'b10:   f_beats_left = 4'd7;
            default: f_beats_left = 4'd15;
        endcase
    endfunction

    logic          w_any_req, w_pick, w_req_g, w_final, w_wrap, w_page_cross;
    logic [DW-1:0] w_hwdata_g;
    logic [4:0]    w_len;
    logic [AW-1:0] w_step, w_wrap_mask, w_inc_addr, w_next_addr;

    assign w_any_req    = m0_req | m1_req;
    assign w_pick       = (m0_req & m1_req) ? ~r_last_grant : m1_req;
    assign w_req_g      = r_owner ? m1_req : m0_req;
    assign w_hwdata_g   = r_owner ? m1_hwdata : m0_hwdata;
    assign w_final      = (r_hburst == 3'b001) ? ~w_req_g : (r_beats_left == 4'd0);
    assign w_wrap       = ~r_hburst[0] & (r_hburst != 3'b000);
    assign w_len        = {1'b0, f_beats_left(r_hburst)} + 5'd1;
    assign w_step       = AW'(1) << r_hsize;
    assign w_wrap_mask  = (AW'(w_len) << r_hsize) - AW'(1);
    assign w_inc_addr   = r_haddr + w_step;
    assign w_next_addr  = w_wrap ? ((r_haddr & ~w_wrap_mask) | (w_inc_addr & w_wrap_mask))
                                 : w_inc_addr;
    assign w_page_cross = ~w_wrap & (w_next_addr[AW-1:10] != r_haddr[AW-1:10]);

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)          w_next = S_ADDR;
            S_ADDR:  if (hready && w_final)  w_next = S_LAST;
            S_LAST:  if (hready)             w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge hreset) begin
        if (hreset) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_m0_grant   <= 1'b0;
            r_m1_grant   <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
            r_haddr      <= '0;
            r_htrans     <= HT_IDLE;
            r_hwrite     <= 1'b0;
            r_hsize      <= '0;
            r_hburst     <= '0;
            r_hsel       <= '0;
            r_hwdata     <= '0;
            r_beats_left <= '0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: if (w_any_req) begin
                    r_owner      <= w_pick;
                    r_last_grant <= w_pick;
                    r_m0_grant   <= ~w_pick;
                    r_m1_grant   <= w_pick;
                    r_enable     <= 1'b1;
                    r_busy       <= 1'b1;
                    r_htrans     <= HT_NONSEQ;
                    r_haddr      <= w_pick ? m1_haddr  : m0_haddr;
                    r_hwrite     <= w_pick ? m1_hwrite : m0_hwrite;
                    r_hsize      <= w_pick ? m1_hsize  : m0_hsize;
                    r_hburst     <= w_pick ? m1_hburst : m0_hburst;
                    r_hsel       <= w_pick ? m1_hsel   : m0_hsel;
                    r_beats_left <= f_beats_left(w_pick ? m1_hburst : m0_hburst);
                end
                S_ADDR: if (hready) begin
                    r_hwdata <= w_hwdata_g;
                    r_m0_ack <= ~r_owner;
                    r_m1_ack <= r_owner;
                    if (w_final) begin
                        r_htrans <= HT_IDLE;
                    end else begin
                        r_haddr      <= w_next_addr;
                        r_htrans     <= w_page_cross ? HT_NONSEQ : HT_SEQ;
                        r_beats_left <= r_beats_left - 4'd1;
                    end
                end
                S_LAST: if (hready) begin
                    r_m0_grant <= 1'b0;
                    r_m1_grant <= 1'b0;
                    r_enable   <= 1'b0;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign m0_grant    = r_m0_grant;
    assign m1_grant    = r_m1_grant;
    assign m0_beat_ack = r_m0_ack;
    assign m1_beat_ack = r_m1_ack;
    assign out_enable  = r_enable;
    assign out_haddr   = r_haddr;
    assign out_htrans  = r_htrans;
    assign out_hwrite  = r_hwrite;
    assign out_hsize   = r_hsize;
    assign out_hburst  = r_hburst;
    assign out_hsel    = r_hsel;
    assign out_hwdata  = r_hwdata;
    assign busy        = r_busy;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb/tb_ahb_master_arbiter.sv - randomized self-checking bench for ahb_master_arbiter
module tb_ahb_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          hreset;
    logic          m0_req, m1_req, m0_hwrite, m1_hwrite, hready;
    logic [AW-1:0] m0_haddr, m1_haddr;
    logic [2:0]    m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [1:0]    m0_hsel, m1_hsel;
    logic [DW-1:0] m0_hwdata, m1_hwdata;
    logic          m0_grant, m1_grant, m0_beat_ack, m1_beat_ack;
    logic          out_enable, out_hwrite, busy;
    logic [AW-1:0] out_haddr;
    logic [1:0]    out_htrans, out_hsel;
    logic [2:0]    out_hsize, out_hburst;
    logic [DW-1:0] out_hwdata;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .hreset(hreset),
        .m0_req(m0_req), .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize),
        .m0_hburst(m0_hburst), .m0_hsel(m0_hsel), .m0_hwdata(m0_hwdata),
        .m0_grant(m0_grant), .m0_beat_ack(m0_beat_ack),
        .m1_req(m1_req), .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize),
        .m1_hburst(m1_hburst), .m1_hsel(m1_hsel), .m1_hwdata(m1_hwdata),
        .m1_grant(m1_grant), .m1_beat_ack(m1_beat_ack),
        .hready(hready), .out_enable(out_enable), .out_haddr(out_haddr),
        .out_htrans(out_htrans), .out_hwrite(out_hwrite), .out_hsize(out_hsize),
        .out_hburst(out_hburst), .out_hsel(out_hsel), .out_hwdata(out_hwdata), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit            last_g;
    logic [DW-1:0] exp_hwdata;
    logic [AW-1:0] d_addr [2];
    logic [2:0]    d_burst[2];
    logic [2:0]    d_size [2];
    logic          d_write[2];
    logic [1:0]    d_sel  [2];
    bit            stall_rand;
    int            stall_beat;
    int            stall_len;

    function automatic int beats_of(input logic [2:0] b, input int incr_len);
        case (b)
            3'd0:       return 1;
            3'd1:       return incr_len;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_grants"}, {m0_grant, m1_grant, m0_beat_ack, m1_beat_ack}, 4'b0);
        check({tag, "_en_busy"}, {out_enable, busy}, 2'b0);
        check({tag, "_htrans"}, out_htrans, 2'b00);
        check({tag, "_haddr"}, out_haddr, 0);
        check({tag, "_hwdata"}, out_hwdata, 0);
        check({tag, "_desc"}, {out_hwrite, out_hsize, out_hburst, out_hsel}, 9'b0);
    endtask

    task automatic set_req(input bit who, input logic v);
        if (who) m1_req = v;
        else     m0_req = v;
    endtask

    // Entered and left at a negedge with the DUT idle
    task automatic run_burst(input logic [1:0] reqs, input int incr_len);
        bit            w, hr, exp_ack, wrap;
        int            n, st;
        logic [AW-1:0] a, prev, s, bsz;
        logic [DW-1:0] d;
        logic [1:0]    et;
        m0_haddr = d_addr[0];  m0_hburst = d_burst[0]; m0_hsize = d_size[0];
        m0_hwrite = d_write[0]; m0_hsel = d_sel[0];
        m1_haddr = d_addr[1];  m1_hburst = d_burst[1]; m1_hsize = d_size[1];
        m1_hwrite = d_write[1]; m1_hsel = d_sel[1];
        m0_req = reqs[0];
        m1_req = reqs[1];
        hready = 1'b1;
        w = (reqs == 2'b11) ? !last_g : reqs[1];
        @(negedge clk);
        last_g = w;
        check("grant", {m0_grant, m1_grant}, {!w, w});
        check("busy_en", {busy, out_enable}, 2'b11);
        check("desc", {out_hwrite, out_hsize, out_hburst, out_hsel},
              {d_write[w], d_size[w], d_burst[w], d_sel[w]});
        n = beats_of(d_burst[w], incr_len);
        wrap = !d_burst[w][0] && (d_burst[w] != 3'd0);
        a = d_addr[w];
        s = 32'd1 << d_size[w];
        et = 2'b10;
        exp_ack = 1'b0;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            if (w) begin m1_hwdata = d; m0_hwdata = $urandom; end
            else   begin m0_hwdata = d; m1_hwdata = $urandom; end
            st = 0;
            do begin
                check("haddr", out_haddr, a);
                check("htrans", out_htrans, et);
                check("ack", {m0_beat_ack, m1_beat_ack}, {exp_ack && !w, exp_ack && w});
                check("hwdata", out_hwdata, exp_hwdata);
                if (stall_rand) hr = ($urandom_range(0, 3) != 0) || (st >= 6);
                else            hr = !(k == stall_beat && st < stall_len);
                hready = hr;
                if (d_burst[w] == 3'd1) set_req(w, k < n - 1);
                else                    set_req(w, 1'($urandom_range(0, 1)));
                set_req(!w, 1'($urandom_range(0, 1)));
                @(negedge clk);
                st++;
                exp_ack = hr;
                if (hr) exp_hwdata = d;
            end while (!hr);
            prev = a;
            if (wrap) begin
                bsz = n * s;
                a = (a & ~(bsz - 1)) | ((a + s) & (bsz - 1));
            end else begin
                a = a + s;
            end
            et = (d_burst[w][0] && ((a >> 10) != (prev >> 10))) ? 2'b10 : 2'b11;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        st = 0;
        do begin
            check("last_htrans", out_htrans, 2'b00);
            check("last_busy", {busy, out_enable, m0_grant, m1_grant}, {2'b11, !w, w});
            check("last_ack", {m0_beat_ack, m1_beat_ack}, {exp_ack && !w, exp_ack && w});
            check("last_hwdata", out_hwdata, exp_hwdata);
            hr = stall_rand ? (($urandom_range(0, 2) != 0) || st >= 4) : 1'b1;
            hready = hr;
            @(negedge clk);
            st++;
            exp_ack = 1'b0;
        end while (!hr);
        check("idle_ctl", {m0_grant, m1_grant, busy, out_enable, m0_beat_ack, m1_beat_ack}, 6'b0);
        check("idle_htrans", out_htrans, 2'b00);
        check("idle_hwdata", out_hwdata, exp_hwdata);
        hready = 1'b1;
    endtask

    task automatic set_desc(input bit who, input logic [AW-1:0] a, input logic [2:0] b,
                            input logic [2:0] sz, input logic wr);
        d_addr[who] = a; d_burst[who] = b; d_size[who] = sz; d_write[who] = wr;
        d_sel[who] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [2:0]    rs;
        hreset = 1'b1; hready = 1'b1;
        m0_req = 0; m1_req = 0; m0_hwrite = 0; m1_hwrite = 0;
        m0_haddr = 0; m1_haddr = 0; m0_hsize = 0; m1_hsize = 0;
        m0_hburst = 0; m1_hburst = 0; m0_hsel = 0; m1_hsel = 0;
        m0_hwdata = 0; m1_hwdata = 0;
        last_g = 1'b1; exp_hwdata = '0;
        stall_rand = 1'b0; stall_beat = -1; stall_len = 0;
        for (int i = 0; i < 2; i++) set_desc(1'(i), 0, 3'd0, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        hreset = 1'b0;
        @(negedge clk);

        set_desc(0, 32'h10, 3'd0, 3'd2, 1'b1);
        set_desc(1, 32'h20, 3'd0, 3'd2, 1'b0);
        repeat (3) run_burst(2'b11, 1);

        set_desc(0, 32'h1, 3'd0, 3'd0, 1'b1);
        run_burst(2'b01, 1);
        set_desc(0, 32'h0C, 3'd2, 3'd2, 1'b1);
        run_burst(2'b01, 1);
        set_desc(0, 32'h3FE, 3'd3, 3'd0, 1'b0);
        run_burst(2'b01, 1);
        set_desc(1, 32'h100, 3'd1, 3'd2, 1'b1);
        stall_beat = 1; stall_len = 2;
        run_burst(2'b10, 3);
        stall_beat = -1; stall_len = 0;

        set_desc(1, 32'h40, 3'd2, 3'd2, 1'b1);
        m1_haddr = 32'h40; m1_hburst = 3'd2; m1_hsize = 3'd2; m1_hwrite = 1'b1;
        m1_req = 1'b1; m0_req = 1'b0; hready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 hreset = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        hreset = 1'b0;
        last_g = 1'b1; exp_hwdata = '0;
        set_desc(0, 32'h80, 3'd0, 3'd1, 1'b0);
        run_burst(2'b11, 1);

        stall_rand = 1'b1;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 2; i++) begin
                rs = 3'($urandom_range(0, 2));
                ra = $urandom;
                if ($urandom_range(0, 2) == 0) ra = (ra & ~32'h3FF) | 32'h3F0 | 32'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFF0;
                ra = ra & ~((32'd1 << rs) - 1);
                set_desc(1'(i), ra, 3'($urandom_range(0, 7)), rs, 1'($urandom_range(0, 1)));
            end
            run_burst(2'($urandom_range(1, 3)), $urandom_range(1, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
